hawk_axi_rd_downsizer: RTL and testbench

- Read-channel width converter between the hawk AXI crossbar output and the memory controller read bus.
- Each 512-bit cacheline read (AR plus N+1 beats) becomes one 256-bit AXI read burst of 2(N+1) beats.
- Response beats are packed pairwise back into 512-bit beats.
- One transaction outstanding at a time, in order; this matches current hawk and CPU traffic.

---
 rtl/hacd_pkg.sv | 22 ++
 rtl/hawk_rd_beat_pack.sv | 57 +++++
 rtl/hawk_axi_rd_downsizer.sv | 198 +++++++++++++++++++
 tb/tb_hawk_axi_rd_downsizer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hacd_pkg.sv
// Shared types and constants for the hawk AXI read downsizer.
package hacd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R_LO,
        R_HI,
        R_OUT
    } rd_dsz_state_e;

    localparam logic [2:0] HAWK_MC_ARSIZE  = 3'd5;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Worst-of-two response code; AXI codes order by severity numerically.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hawk_rd_beat_pack.sv
// Packs two half-width read beats into one full-width beat with merged response and last flag.
module hawk_rd_beat_pack
    import hacd_pkg::*;
#(
    parameter int unsigned HALF_W = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                i_clear,
    input  logic                i_load_lo,
    input  logic                i_load_hi,
    input  logic [HALF_W-1:0]   i_data,
    input  logic [1:0]          i_resp,
    input  logic                i_last,
    input  logic                i_err,
    output logic [2*HALF_W-1:0] o_data,
    output logic [1:0]          o_resp,
    output logic                o_last
);

    logic [HALF_W-1:0] r_lo;
    logic [HALF_W-1:0] r_hi;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              r_err;

    // An error seen on either half forces SLVERR on the packed beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lo   <= '0;
            r_hi   <= '0;
            r_resp <= AXI_RESP_OKAY;
            r_last <= 1'b0;
            r_err  <= 1'b0;
        end else if (i_clear) begin
            r_lo   <= '0;
            r_hi   <= '0;
            r_resp <= AXI_RESP_OKAY;
            r_last <= 1'b0;
            r_err  <= 1'b0;
        end else if (i_load_lo) begin
            r_lo   <= i_data;
            r_resp <= i_resp;
            r_err  <= i_err;
        end else if (i_load_hi) begin
            r_hi   <= i_data;
            r_resp <= (r_err | i_err) ? AXI_RESP_SLVERR : resp_max(r_resp, i_resp);
            r_last <= i_last;
            r_err  <= r_err | i_err;
        end
    end

    assign o_data = {r_hi, r_lo};
    assign o_resp = r_resp;
    assign o_last = r_last;

endmodule

// File: rtl/hawk_axi_rd_downsizer.sv
// 512->256 AXI read-channel downsizer, one transaction outstanding.
// Optional protocol checking (ID, RLAST placement) enabled by HAWK_RD_DSZ_ERRCHK_EN.
module hawk_axi_rd_downsizer
    import hacd_pkg::*;
#(
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned ID_W     = 6,
    parameter int unsigned S_DATA_W = 512,
    parameter int unsigned M_DATA_W = 256,
    parameter int unsigned USER_W   = 11
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ID_W-1:0]     s_arid,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic [2:0]          s_arsize,
    input  logic [1:0]          s_arburst,
    input  logic [USER_W-1:0]   s_aruser,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_W-1:0]     s_rid,
    output logic [S_DATA_W-1:0] s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [ID_W-1:0]     m_arid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic [USER_W-1:0]   m_aruser,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [ID_W-1:0]     m_rid,
    input  logic [M_DATA_W-1:0] m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic                err_o
);

    rd_dsz_state_e      r_state;
    logic               r_s_arready;
    logic               r_m_arvalid;
    logic               r_m_rready;
    logic               r_s_rvalid;
    logic [ID_W-1:0]    r_id;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_mlen;
    logic [USER_W-1:0]  r_user;

    logic [8:0]         w_mlen9;
    logic               w_ar_hs;
    logic               w_lo_acc;
    logic               w_hi_acc;
    logic               w_err_lo;
    logic               w_err_hi;
    logic               w_pack_last;
    logic               w_unused;

    // 2*len+1 in 9 bits; bit 8 is dropped for unsupported len > 127.
    assign w_mlen9  = {s_arlen, 1'b1};
    assign w_ar_hs  = r_s_arready & s_arvalid;
    assign w_lo_acc = (r_state == R_LO) & r_m_rready & m_rvalid;
    assign w_hi_acc = (r_state == R_HI) & r_m_rready & m_rvalid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_s_arready <= 1'b0;
            r_m_arvalid <= 1'b0;
            r_m_rready  <= 1'b0;
            r_s_rvalid  <= 1'b0;
            r_id        <= '0;
            r_addr      <= '0;
            r_mlen      <= '0;
            r_user      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ar_hs) begin
                        r_id        <= s_arid;
                        r_addr      <= {s_araddr[ADDR_W-1:6], 6'b0};
                        r_mlen      <= w_mlen9[7:0];
                        r_user      <= s_aruser;
                        r_s_arready <= 1'b0;
                        r_m_arvalid <= 1'b1;
                        r_state     <= AR;
                    end else begin
                        r_s_arready <= 1'b1;
                    end
                end
                AR: begin
                    if (m_arready) begin
                        r_m_arvalid <= 1'b0;
                        r_m_rready  <= 1'b1;
                        r_state     <= R_LO;
                    end
                end
                R_LO: begin
                    if (w_lo_acc) begin
                        r_state <= R_HI;
                    end
                end
                R_HI: begin
                    if (w_hi_acc) begin
                        r_m_rready <= 1'b0;
                        r_s_rvalid <= 1'b1;
                        r_state    <= R_OUT;
                    end
                end
                R_OUT: begin
                    if (s_rready) begin
                        r_s_rvalid <= 1'b0;
                        if (w_pack_last) begin
                            r_s_arready <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_m_rready <= 1'b1;
                            r_state    <= R_LO;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef HAWK_RD_DSZ_ERRCHK_EN
    logic [8:0] r_beat_cnt;
    logic       r_err;
    logic       w_id_bad;

    assign w_id_bad = (m_rid != r_id);
    assign w_err_lo = w_id_bad | m_rlast;
    assign w_err_hi = w_id_bad | (~m_rlast & (r_beat_cnt == {1'b0, r_mlen}));

    // Downstream beat index within the burst plus the sticky error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_beat_cnt <= '0;
            end else if (w_lo_acc | w_hi_acc) begin
                r_beat_cnt <= r_beat_cnt + 9'd1;
            end
            if ((w_lo_acc & w_err_lo) | (w_hi_acc & w_err_hi)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign w_err_lo = 1'b0;
    assign w_err_hi = 1'b0;
    assign err_o    = 1'b0;
`endif

    hawk_rd_beat_pack #(
        .HALF_W (M_DATA_W)
    ) u_pack (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_clear   (w_ar_hs),
        .i_load_lo (w_lo_acc),
        .i_load_hi (w_hi_acc),
        .i_data    (m_rdata),
        .i_resp    (m_rresp),
        .i_last    (m_rlast),
        .i_err     (w_lo_acc ? w_err_lo : w_err_hi),
        .o_data    (s_rdata),
        .o_resp    (s_rresp),
        .o_last    (w_pack_last)
    );

    assign s_arready = r_s_arready;
    assign s_rvalid  = r_s_rvalid;
    assign s_rid     = r_id;
    assign s_rlast   = w_pack_last;
    assign m_arvalid = r_m_arvalid;
    assign m_arid    = r_id;
    assign m_araddr  = r_addr;
    assign m_arlen   = r_mlen;
    assign m_arsize  = HAWK_MC_ARSIZE;
    assign m_arburst = AXI_BURST_INCR;
    assign m_aruser  = r_user;
    assign m_rready  = r_m_rready;

    // Upstream size/burst are implied (full cacheline, INCR); low address bits are masked.
    assign w_unused = ^{s_arsize, s_arburst, s_araddr[5:0], w_mlen9[8], m_rid};

endmodule

// File: tb/tb_hawk_axi_rd_downsizer.sv
// Directed self-checking bench for hawk_axi_rd_downsizer.
module tb_hawk_axi_rd_downsizer;

`ifdef HAWK_RD_DSZ_ERRCHK_EN
    localparam logic ERRCHK = 1'b1;
`else
    localparam logic ERRCHK = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [5:0]   s_arid;
    logic [63:0]  s_araddr;
    logic [7:0]   s_arlen;
    logic [2:0]   s_arsize;
    logic [1:0]   s_arburst;
    logic [10:0]  s_aruser;
    logic         s_arvalid;
    logic         s_arready;
    logic [5:0]   s_rid;
    logic [511:0] s_rdata;
    logic [1:0]   s_rresp;
    logic         s_rlast;
    logic         s_rvalid;
    logic         s_rready;
    logic [5:0]   m_arid;
    logic [63:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    logic [1:0]   m_arburst;
    logic [10:0]  m_aruser;
    logic         m_arvalid;
    logic         m_arready;
    logic [5:0]   m_rid;
    logic [255:0] m_rdata;
    logic [1:0]   m_rresp;
    logic         m_rlast;
    logic         m_rvalid;
    logic         m_rready;
    logic         err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    hawk_axi_rd_downsizer dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .s_arid    (s_arid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_aruser  (s_aruser),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rid     (s_rid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .m_arid    (m_arid),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_aruser  (m_aruser),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rid     (m_rid),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .err_o     (err_o)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one AR upstream and accept it into the DUT; returns once m_arvalid should be up.
    task automatic send_ar(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len);
        s_arid    = id;
        s_araddr  = addr;
        s_arlen   = len;
        s_arsize  = 3'd6;
        s_arburst = 2'b01;
        s_aruser  = 11'h400 | 11'(id);
        s_arvalid = 1'b1;
        #1;
        chk("no_comb_arvalid", 512'(m_arvalid), 512'(1'b0));
        for (int k = 0; k < 20 && s_arready !== 1'b1; k++) @(negedge clk_i);
        chk("s_arready", 512'(s_arready), 512'(1'b1));
        @(negedge clk_i);
        s_arvalid = 1'b0;
    endtask

    task automatic rd(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                      input logic [63:0] exp_addr, input logic [7:0] exp_mlen,
                      input logic [1:0] lo_resp, input logic [1:0] hi_resp, input logic [1:0] exp_resp,
                      input logic bad_lo_last, input logic [5:0] rid, input int bp, input logic exp_err);
        logic [255:0] lo;
        logic [255:0] hi;
        send_ar(id, addr, len);
        chk("m_arvalid", 512'(m_arvalid), 512'(1'b1));
        chk("m_araddr", 512'(m_araddr), 512'(exp_addr));
        chk("m_arlen", 512'(m_arlen), 512'(exp_mlen));
        chk("m_arsize", 512'(m_arsize), 512'(3'd5));
        chk("m_arburst", 512'(m_arburst), 512'(2'b01));
        chk("m_arid", 512'(m_arid), 512'(id));
        chk("m_aruser", 512'(m_aruser), 512'(11'h400 | 11'(id)));
        m_arready = 1'b1;
        @(negedge clk_i);
        m_arready = 1'b0;
        chk("m_arvalid_drop", 512'(m_arvalid), 512'(1'b0));
        for (int b = 0; b <= int'(len); b++) begin
            lo = {8{32'hAAAA_AAAA ^ 32'(b)}};
            hi = {8{32'hBBBB_BBBB ^ 32'(b)}};
            chk("m_rready_lo", 512'(m_rready), 512'(1'b1));
            m_rvalid = 1'b1;
            m_rdata  = lo;
            m_rresp  = lo_resp;
            m_rlast  = bad_lo_last && (b == 0);
            m_rid    = rid;
            @(negedge clk_i);
            chk("m_rready_hi", 512'(m_rready), 512'(1'b1));
            chk("s_rvalid_mid", 512'(s_rvalid), 512'(1'b0));
            m_rdata  = hi;
            m_rresp  = hi_resp;
            m_rlast  = (b == int'(len));
            @(negedge clk_i);
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
            chk("s_rvalid", 512'(s_rvalid), 512'(1'b1));
            chk("s_rdata", s_rdata, {hi, lo});
            chk("s_rid", 512'(s_rid), 512'(id));
            chk("s_rlast", 512'(s_rlast), 512'(b == int'(len)));
            chk("s_rresp", 512'(s_rresp), 512'(exp_resp));
            chk("err_o", 512'(err_o), 512'(exp_err));
            for (int c = 0; c < bp; c++) begin
                @(negedge clk_i);
                chk("bp_m_rready", 512'(m_rready), 512'(1'b0));
                chk("bp_s_rvalid", 512'(s_rvalid), 512'(1'b1));
                chk("bp_s_rdata", s_rdata, {hi, lo});
            end
            s_rready = 1'b1;
            @(negedge clk_i);
            s_rready = 1'b0;
        end
        chk("end_s_rvalid", 512'(s_rvalid), 512'(1'b0));
        chk("end_s_arready", 512'(s_arready), 512'(1'b1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni    = 1'b0;
        s_arid    = '0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        s_aruser  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = 1'b0;
        m_rid     = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
        m_rvalid  = 1'b0;
        #13;
        chk("rst_s_arready", 512'(s_arready), 512'(1'b0));
        chk("rst_m_arvalid", 512'(m_arvalid), 512'(1'b0));
        chk("rst_s_rvalid", 512'(s_rvalid), 512'(1'b0));
        chk("rst_m_rready", 512'(m_rready), 512'(1'b0));
        chk("rst_err_o", 512'(err_o), 512'(1'b0));
        chk("rst_s_rdata", s_rdata, 512'(0));
        chk("rst_s_rid", 512'(s_rid), 512'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // single beat, multi beat, unaligned with back-pressure, response merges
        rd(6'd0, 64'h1000_0040, 8'd0, 64'h1000_0040, 8'd1, 2'b00, 2'b00, 2'b00, 1'b0, 6'd0, 0, 1'b0);
        rd(6'd3, 64'h2000_0000, 8'd3, 64'h2000_0000, 8'd7, 2'b00, 2'b00, 2'b00, 1'b0, 6'd3, 0, 1'b0);
        rd(6'd1, 64'h3000_007F, 8'd0, 64'h3000_0040, 8'd1, 2'b00, 2'b00, 2'b00, 1'b0, 6'd1, 5, 1'b0);
        rd(6'd2, 64'h4000_0080, 8'd1, 64'h4000_0080, 8'd3, 2'b00, 2'b11, 2'b11, 1'b0, 6'd2, 1, 1'b0);
        rd(6'd2, 64'h5000_00C5, 8'd0, 64'h5000_00C0, 8'd1, 2'b10, 2'b01, 2'b10, 1'b0, 6'd2, 0, 1'b0);

`ifdef HAWK_RD_DSZ_ERRCHK_EN
        // ID mismatch on every beat
        rd(6'd0, 64'h7000_0000, 8'd0, 64'h7000_0000, 8'd1, 2'b00, 2'b00, 2'b10, 1'b0, 6'd5, 0, 1'b1);
        chk("err_sticky", 512'(err_o), 512'(1'b1));
`endif

        // RLAST on the low beat: ignored by default, flagged with the checker
        rd(6'd4, 64'h6000_0000, 8'd0, 64'h6000_0000, 8'd1, 2'b00, 2'b00,
           ERRCHK ? 2'b10 : 2'b00, 1'b1, 6'd4, 0, ERRCHK);

        // mid-burst reset with the largest supported length
        send_ar(6'd9, 64'h8000_0040, 8'd127);
        chk("len127_m_arlen", 512'(m_arlen), 512'(8'hFF));
        m_arready = 1'b1;
        @(negedge clk_i);
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = {8{32'h1234_5678}};
        m_rresp   = 2'b00;
        m_rid     = 6'd9;
        @(negedge clk_i);
        m_rvalid  = 1'b0;
        chk("pre_rst_m_rready", 512'(m_rready), 512'(1'b1));
        chk("pre_rst_err_o", 512'(err_o), 512'(ERRCHK));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_m_rready", 512'(m_rready), 512'(1'b0));
        chk("mid_rst_m_arvalid", 512'(m_arvalid), 512'(1'b0));
        chk("mid_rst_s_rvalid", 512'(s_rvalid), 512'(1'b0));
        chk("mid_rst_s_arready", 512'(s_arready), 512'(1'b0));
        chk("mid_rst_err_o", 512'(err_o), 512'(1'b0));
        chk("mid_rst_s_rdata", s_rdata, 512'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_s_arready", 512'(s_arready), 512'(1'b1));
        rd(6'd7, 64'h9000_0100, 8'd1, 64'h9000_0100, 8'd3, 2'b01, 2'b00, 2'b01, 1'b0, 6'd7, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
